// File: rtl/fmap_streamer_pkg.sv
// Shared types for the feature-map streamer: FSM states and the per-pixel markers.
// The skid buffer stores each marker group next to the pixel data it belongs to.
package fmap_streamer_pkg;

  localparam int MARKER_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Markers travel with their pixel from the read side to the output port.
  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } marker_t;

  // Derive a pixel's markers from its position in the frame.
  function automatic marker_t make_marker(input logic first_col, input logic last_col,
                                          input logic first_row, input logic last_row);
    marker_t m;
    m.sol = first_col;
    m.eol = last_col;
    m.sof = first_col & first_row;
    m.eof = last_col & last_row;
    return m;
  endfunction

endpackage

// File: rtl/fmap_skid_buf.sv
// Two-entry FIFO of pixel beats (data plus markers) sitting between the RAM
// read port and the output stream. The head entry is visible combinationally.
module fmap_skid_buf
  import fmap_streamer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] in_data,
  input  marker_t           in_mark,
  output logic [DATA_W-1:0] out_data,
  output marker_t           out_mark,
  output logic [1:0]        count
);

  logic [DATA_W-1:0]   data_mem [2];
  logic [MARKER_W-1:0] mark_mem [2];
  logic                wr_ptr;
  logic                rd_ptr;

  // Storage, pointers and occupancy; the streamer's credit logic guarantees no overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_mem[0] <= '0;
      data_mem[1] <= '0;
      mark_mem[0] <= '0;
      mark_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= in_data;
        mark_mem[wr_ptr] <= in_mark;
      end
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_data = data_mem[rd_ptr];
  assign out_mark = marker_t'(mark_mem[rd_ptr]);

endmodule

// File: rtl/fmap_streamer.sv
// Reads one IMG_W x IMG_H feature map from buffer RAM in raster order and streams
// it out over valid/ready with line/frame markers. A pixel whose read returns
// while the skid buffer is empty is forwarded straight from the RAM data port,
// which hides the one-cycle read latency; otherwise it is queued in the buffer.
module fmap_streamer
  import fmap_streamer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sol,
  output logic              m_eol,
  output logic              m_sof,
  output logic              m_eof
);

  localparam int N     = IMG_W * IMG_H;
  localparam int IDX_W = $clog2(N);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic              inflight_reg;
  marker_t           inflight_mark_reg;

  logic [1:0]        buf_count;
  logic [DATA_W-1:0] buf_data;
  marker_t           buf_mark;
  logic              buf_nonempty, buf_push, buf_pop;
  logic              xfer, rd_issue, last_read;
  logic [2:0]        occ_after;
  marker_t           rd_mark, out_mark;

  // Output side: buffer head has priority, else the read returning this cycle.
  assign buf_nonempty = (buf_count != 2'd0);
  assign m_valid      = buf_nonempty | inflight_reg;
  assign xfer         = m_valid & m_ready;
  assign buf_pop      = xfer & buf_nonempty;
  assign buf_push     = inflight_reg & ~(xfer & ~buf_nonempty);
  assign out_mark     = buf_nonempty ? buf_mark : (inflight_reg ? inflight_mark_reg : '0);
  assign m_data       = buf_nonempty ? buf_data : (inflight_reg ? mem_rd_data : '0);
  assign m_sol        = out_mark.sol;
  assign m_eol        = out_mark.eol;
  assign m_sof        = out_mark.sof;
  assign m_eof        = out_mark.eof;

  // Read side: issue only while pixels held plus in flight, after this cycle's pop, stay below 2.
  assign occ_after = 3'(buf_count) + 3'(inflight_reg) - 3'(xfer);
  assign rd_issue  = (state_reg == STREAM) && (occ_after < 3'd2);
  assign last_read = rd_issue && (idx_reg == IDX_W'(N - 1));
  assign mem_rd_en = rd_issue;
  assign mem_addr  = base_reg + ADDR_W'(idx_reg);
  assign rd_mark   = make_marker(col_reg == '0, col_reg == COL_W'(IMG_W - 1),
                                 row_reg == '0, row_reg == ROW_W'(IMG_H - 1));

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: frame ends on the handshake of the eof-tagged pixel.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (last_read) state_next = DRAIN;
      DRAIN:   if (xfer && out_mark.eof) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Raster counters and base address; restarted when a frame is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg <= '0;
      idx_reg  <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
    end else if (state_reg == IDLE && start) begin
      base_reg <= base_addr;
      idx_reg  <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
    end else if (rd_issue) begin
      idx_reg <= idx_reg + 1'b1;
      if (col_reg == COL_W'(IMG_W - 1)) begin
        col_reg <= '0;
        row_reg <= row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Track the outstanding RAM read and the markers of the pixel it will return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_reg      <= 1'b0;
      inflight_mark_reg <= '0;
    end else begin
      inflight_reg      <= rd_issue;
      inflight_mark_reg <= rd_mark;
    end
  end

  fmap_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .push    (buf_push),
    .pop     (buf_pop),
    .in_data (mem_rd_data),
    .in_mark (inflight_mark_reg),
    .out_data(buf_data),
    .out_mark(buf_mark),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_fmap_streamer.sv
// Directed bench for fmap_streamer on a 4x3 frame with a registered-read RAM model.
module tb_fmap_streamer;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 10;
  localparam int N      = IMG_W * IMG_H;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy, done, mem_rd_en, m_valid, m_sol, m_eol, m_sof, m_eof;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b0;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [5:0]        ptn_bits = 6'b101001;  // bit0 first: 1,0,0,1,0,1

  int checks = 0;
  int errors = 0;

  fmap_streamer #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sol(m_sol), .m_eol(m_eol), .m_sof(m_sof), .m_eof(m_eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_beat(input int b, input int j);
    logic [7:0] d;
    d = 8'((b + j) % DEPTH);
    return {20'd0, d, 1'(j % IMG_W == 0), 1'(j % IMG_W == IMG_W - 1), 1'(j == 0), 1'(j == N - 1)};
  endfunction

  function automatic logic [31:0] obs_beat();
    return {20'd0, m_data, m_sol, m_eol, m_sof, m_eof};
  endfunction

  function automatic logic [31:0] all_outs();
    return {6'd0, busy, done, mem_rd_en, m_valid, m_sol, m_eol, m_sof, m_eof, mem_addr, m_data};
  endfunction

  // pat: 0 = always ready, 1 = 1,0,0,1,0,1 repeating, 2 = stalled for 20 cycles.
  // poke: pulse start again on the 5th transfer and in the done cycle.
  task automatic run_frame(input int base, input int pat, input bit poke, input string name);
    int  xfers = 0, reads = 0, dones = 0, first_v = -1, last_x = -1, done_c = -1;
    int  occ_bad = 0, drop_bad = 0, extra_reads = 0;
    bit  prev_stall = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(base); m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 200 && (done_c < 0 || cyc <= done_c + 3); cyc++) begin
      case (pat)
        0:       m_ready = 1'b1;
        1:       m_ready = ptn_bits[(cyc - 1) % 6];
        default: m_ready = (cyc > 20);
      endcase
      #1;
      if (cyc == 1) begin
        check({name, "_busy1"}, 32'(busy), 32'd1);
        check({name, "_rden1"}, 32'(mem_rd_en), 32'd1);
        check({name, "_addr1"}, 32'(mem_addr), 32'(base));
      end
      if (reads - xfers > 2) occ_bad++;
      if (prev_stall && !m_valid) drop_bad++;
      if (m_valid) begin
        if (first_v < 0) first_v = cyc;
        check({name, "_pix"}, obs_beat(), exp_beat(base, xfers));
      end
      if (pat == 2 && cyc == 20) begin
        check({name, "_reads_stalled"}, 32'(reads), 32'd2);
        check({name, "_valid_stalled"}, 32'(m_valid), 32'd1);
      end
      if (done) begin
        dones++;
        done_c = cyc;
        if (poke) start = 1'b1;
      end
      if (done_c >= 0 && cyc > done_c && mem_rd_en) extra_reads++;
      if (mem_rd_en) begin
        check({name, "_rdaddr"}, 32'(mem_addr), 32'((base + reads) % DEPTH));
        reads++;
      end
      if (m_valid && m_ready) begin
        xfers++;
        last_x = cyc;
        if (poke && xfers == 5) start = 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      @(negedge clk);
      start = 1'b0;
    end
    m_ready = 1'b0;
    #1;
    check({name, "_xfers"}, 32'(xfers), 32'(N));
    check({name, "_reads"}, 32'(reads), 32'(N));
    check({name, "_dones"}, 32'(dones), 32'd1);
    check({name, "_done_lat"}, 32'(done_c), 32'(last_x + 1));
    check({name, "_occ_over2"}, 32'(occ_bad), 32'd0);
    check({name, "_valid_drop"}, 32'(drop_bad), 32'd0);
    check({name, "_extra_reads"}, 32'(extra_reads), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_idle_valid"}, 32'(m_valid), 32'd0);
    if (pat == 0) begin
      check({name, "_first_valid"}, 32'(first_v), 32'd2);
      check({name, "_done_cycle"}, 32'(done_c), 32'(N + 2));
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);

    // Reset state
    #1;
    check("reset_outs", all_outs(), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("idle_after_reset", all_outs(), 32'd0);

    run_frame(0, 0, 1'b0, "basic");
    run_frame(0, 1, 1'b0, "bp");
    run_frame(DEPTH - 3, 0, 1'b0, "wrap");
    run_frame(0, 0, 1'b1, "poke");

    // Reset in the middle of a frame after 6 transfers
    @(negedge clk);
    start = 1'b1; base_addr = '0;
    @(negedge clk);
    start = 1'b0; m_ready = 1'b1; n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      #1;
      if (m_valid && m_ready) n++;
      @(negedge clk);
    end
    check("abort_xfers", 32'(n), 32'd6);
    m_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("abort_outs", all_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (done || busy) n++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(n), 32'd0);
    run_frame(0, 0, 1'b0, "rst");

    run_frame(0, 2, 1'b0, "stall");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
